// File: rtl/ahb_slave_if_gen2.sv
// ahb_slave_if_gen2 -- AHB slave front end for the AHB-APB bridge.
// Decodes NUM_SEL peripheral regions and holds the accepted address phase.
// Mapped transfers are queued in a request FIFO toward the APB controller.
// Writes are posted. A read inserts wait states until its data returns.
// Unmapped addresses get the two-cycle AHB ERROR response.
// Ports:
//   hclk, hreset             clock, asynchronous active-high reset
//   hsel_bridge, hready_in,
//   htrans, hwrite, haddr,
//   hwdata                   AHB request side
//   hready_out, hresp,
//   hrdata                   AHB response side
//   req_valid/req_ready,
//   req_write/addr/wdata/sel FIFO head toward the APB controller
//   rd_valid, rd_data        read data return from the APB controller
module ahb_slave_if_gen2 #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       NUM_SEL      = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned       REGION_SHIFT = 26,
  parameter int unsigned       FIFO_DEPTH   = 2
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               hsel_bridge,
  input  logic               hready_in,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  output logic               hready_out,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_write,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  output logic [NUM_SEL-1:0] req_sel,
  input  logic               rd_valid,
  input  logic [DATA_W-1:0]  rd_data
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_WRITE,
    DP_READ,
    DP_ERR1,
    DP_ERR2
  } state_t;

  state_t state, state_nxt;

  // Address decode
  logic [ADDR_W-1:0]  idx;
  logic               mapped;
  logic [NUM_SEL-1:0] sel;

  always_comb begin
    idx    = (haddr - BASE_ADDR) >> REGION_SHIFT;
    mapped = (haddr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SEL));
    sel    = '0;
    for (int unsigned i = 0; i < NUM_SEL; i++) begin
      if (mapped && (idx == ADDR_W'(i))) sel[i] = 1'b1;
    end
  end

  logic accept, take;
  assign accept = hready_in && hsel_bridge && ((htrans == 2'b10) || (htrans == 2'b11));
  // A new address phase only lands when the current data phase completes.
  assign take   = accept && hready_out;

  // Address-phase holding register
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_SEL-1:0] sel_q;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q <= '0;
      sel_q  <= '0;
    end else if (take) begin
      addr_q <= haddr;
      sel_q  <= sel;
    end
  end

  // Request FIFO storage and bookkeeping
  logic              fifo_write [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [NUM_SEL-1:0] fifo_sel  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              has_space, push, pop;
  logic              push_write;
  logic [DATA_W-1:0] push_wdata;

  // Space is judged on the pre-pop count, so a full FIFO never push/pops.
  assign has_space = (count < CNT_W'(FIFO_DEPTH));
  assign req_valid = (count != '0);
  assign pop       = req_valid && req_ready;

  // Read tracking and response data
  logic              issued;
  logic              rd_done;
  logic [DATA_W-1:0] hrdata_q;

  // State register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= DP_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (hready_out) begin
      if (take)        state_nxt = !mapped ? DP_ERR1 : (hwrite ? DP_WRITE : DP_READ);
      else             state_nxt = DP_IDLE;
    end else if (state == DP_ERR1) begin
      state_nxt = DP_ERR2;
    end
  end

  // Output logic
  always_comb begin
    hready_out = 1'b1;
    hresp      = 2'b00;
    push       = 1'b0;
    push_write = 1'b0;
    push_wdata = '0;
    rd_done    = 1'b0;
    unique case (state)
      DP_WRITE: begin
        push       = has_space;
        push_write = 1'b1;
        push_wdata = hwdata;
        hready_out = has_space;
      end
      DP_READ: begin
        push       = has_space && !issued;
        rd_done    = rd_valid && issued;
        hready_out = rd_done;
      end
      DP_ERR1: begin
        hresp      = 2'b01;
        hready_out = 1'b0;
      end
      DP_ERR2: begin
        hresp      = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      issued   <= 1'b0;
      hrdata_q <= '0;
    end else begin
      if (rd_done) begin
        issued   <= 1'b0;
        hrdata_q <= rd_data;
      end else if (push && (state == DP_READ)) begin
        issued   <= 1'b1;
      end
    end
  end

  assign hrdata = rd_done ? rd_data : hrdata_q;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (push) begin
      fifo_write[wr_ptr] <= push_write;
      fifo_addr[wr_ptr]  <= addr_q;
      fifo_wdata[wr_ptr] <= push_wdata;
      fifo_sel[wr_ptr]   <= sel_q;
    end
  end

  // Head fields read as zero while the FIFO is empty.
  assign req_write = req_valid && fifo_write[rd_ptr];
  assign req_addr  = req_valid ? fifo_addr[rd_ptr]  : '0;
  assign req_wdata = req_valid ? fifo_wdata[rd_ptr] : '0;
  assign req_sel   = req_valid ? fifo_sel[rd_ptr]   : '0;

endmodule

// File: tb/tb_ahb_slave_if_gen2.sv
module tb_ahb_slave_if_gen2;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel_bridge;
  logic        hready_in;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_sel;
  logic        rd_valid;
  logic [31:0] rd_data;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } entry_t;

  entry_t sbq[$];
  entry_t mon_e;

  always #5 hclk = ~hclk;

  // Single-slave system: the bus HREADY is this slave's own HREADY.
  assign hready_in = hready_out;

  ahb_slave_if_gen2 #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_SEL     (3),
    .BASE_ADDR   (32'h8000_0000),
    .REGION_SHIFT(26),
    .FIFO_DEPTH  (2)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel_bridge(hsel_bridge),
    .hready_in  (hready_in),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_sel    (req_sel),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data)
  );

  // Scoreboard: every handshake at the FIFO head must match the oldest expectation.
  always @(negedge hclk) begin
    if (!hreset && req_valid && req_ready) begin
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got w=%b a=%h d=%h s=%b, expected no request",
                 req_write, req_addr, req_wdata, req_sel);
      end else begin
        mon_e = sbq.pop_front();
        if ({req_write, req_addr, req_wdata, req_sel} !== {mon_e.w, mon_e.a, mon_e.d, mon_e.s}) begin
          mismatched++;
          $display("FAIL sb_entry: got w=%b a=%h d=%h s=%b, expected w=%b a=%h d=%h s=%b",
                   req_write, req_addr, req_wdata, req_sel, mon_e.w, mon_e.a, mon_e.d, mon_e.s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel_bridge = 1'b0;
    htrans      = 2'b00;
    hwrite      = 1'b0;
    haddr       = '0;
  endtask

  task automatic addr_phase(input logic [1:0] t, input logic w, input logic [31:0] a);
    hsel_bridge = 1'b1;
    htrans      = t;
    hwrite      = w;
    haddr       = a;
  endtask

  task automatic expect_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] s);
    entry_t e;
    e = '{w, a, d, s};
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    hreset = 1'b1; bus_idle(); hwdata = '0;
    req_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    compared++;
    if (hready_out !== 1'b1) begin mismatched++; $display("FAIL rst_hready: got %b, expected 1", hready_out); end
    compared++;
    if (hresp !== 2'b00) begin mismatched++; $display("FAIL rst_hresp: got %b, expected 00", hresp); end
    compared++;
    if (hrdata !== 32'h0) begin mismatched++; $display("FAIL rst_hrdata: got %h, expected 0", hrdata); end
    compared++;
    if ({req_valid, req_write, req_addr, req_wdata, req_sel} !== 69'h0) begin
      mismatched++;
      $display("FAIL rst_req: got v=%b w=%b a=%h d=%h s=%b, expected all 0",
               req_valid, req_write, req_addr, req_wdata, req_sel);
    end
    next_cycle();
    hreset = 1'b0;
  endtask

  task automatic test_single_write();
    req_ready = 1'b1;
    addr_phase(2'b10, 1'b1, 32'h8400_0010);
    expect_req(1'b1, 32'h8400_0010, 32'hDEAD_BEEF, 3'b010);
    @(negedge hclk);
    next_cycle();
    bus_idle(); hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    compared++;
    if ({hready_out, hresp} !== 3'b100) begin
      mismatched++; $display("FAIL sw_zero_wait: got ready=%b resp=%b, expected 1/00", hready_out, hresp);
    end
    next_cycle();
    hwdata = '0;
    @(negedge hclk);
    compared++;
    if ({req_valid, req_write, req_wdata, req_sel} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 3'b010}) begin
      mismatched++;
      $display("FAIL sw_head: got v=%b w=%b d=%h s=%b, expected 1 1 deadbeef 010",
               req_valid, req_write, req_wdata, req_sel);
    end
    next_cycle();
    @(negedge hclk);
    compared++;
    if (req_valid !== 1'b0) begin mismatched++; $display("FAIL sw_popped: got %b, expected 0", req_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int n;
    req_ready = 1'b0;
    addr_phase(2'b10, 1'b1, 32'h8000_0000);
    expect_req(1'b1, 32'h8000_0000, 32'h0000_00A0, 3'b001);
    @(negedge hclk);
    next_cycle();
    hwdata = 32'h0000_00A0; addr_phase(2'b11, 1'b1, 32'h8000_0004);
    expect_req(1'b1, 32'h8000_0004, 32'h0000_00A1, 3'b001);
    @(negedge hclk);
    compared++;
    if (hready_out !== 1'b1) begin mismatched++; $display("FAIL b2b_w0_ready: got %b, expected 1", hready_out); end
    next_cycle();
    hwdata = 32'h0000_00A1; addr_phase(2'b11, 1'b1, 32'h8000_0008);
    expect_req(1'b1, 32'h8000_0008, 32'h0000_00A2, 3'b001);
    @(negedge hclk);
    compared++;
    if (hready_out !== 1'b1) begin mismatched++; $display("FAIL b2b_w1_ready: got %b, expected 1", hready_out); end
    next_cycle();
    hwdata = 32'h0000_00A2; bus_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      compared++;
      if (hready_out !== 1'b0) begin mismatched++; $display("FAIL b2b_w2_stall: got %b, expected 0", hready_out); end
      compared++;
      if ({req_valid, req_addr} !== {1'b1, 32'h8000_0000}) begin
        mismatched++; $display("FAIL b2b_head_hold: got v=%b a=%h, expected 1 80000000", req_valid, req_addr);
      end
      next_cycle();
    end
    req_ready = 1'b1;
    @(negedge hclk);
    compared++;
    if (hready_out !== 1'b0) begin mismatched++; $display("FAIL b2b_full_pop: got %b, expected 0", hready_out); end
    next_cycle();
    req_ready = 1'b0;
    @(negedge hclk);
    compared++;
    if (hready_out !== 1'b1) begin mismatched++; $display("FAIL b2b_w2_done: got %b, expected 1", hready_out); end
    next_cycle();
    hwdata = '0; req_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      next_cycle();
      n++;
    end
    compared++;
    if (sbq.size() != 0) begin mismatched++; $display("FAIL b2b_drain: got %0d pending, expected 0", sbq.size()); end
    @(negedge hclk);
    compared++;
    if (req_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_empty: got %b, expected 0", req_valid); end
    next_cycle();
    req_ready = 1'b0;
  endtask

  task automatic test_read();
    int low;
    req_ready = 1'b1;
    addr_phase(2'b10, 1'b0, 32'h8800_0004);
    expect_req(1'b0, 32'h8800_0004, 32'h0, 3'b100);
    @(negedge hclk);
    next_cycle();
    // Return strobe before the request is issued must be ignored.
    bus_idle(); rd_valid = 1'b1; rd_data = 32'hBAD0_BAD0;
    low = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge hclk);
      if (hready_out === 1'b0) low++;
      if (c == 1) begin
        compared++;
        if ({req_valid, req_write, req_sel} !== {1'b1, 1'b0, 3'b100}) begin
          mismatched++;
          $display("FAIL rd_head: got v=%b w=%b s=%b, expected 1 0 100", req_valid, req_write, req_sel);
        end
      end
      next_cycle();
      rd_valid = 1'b0;
    end
    rd_valid = 1'b1; rd_data = 32'h1234_5678;
    @(negedge hclk);
    compared++;
    if (low != 4) begin mismatched++; $display("FAIL rd_wait_states: got %0d, expected 4", low); end
    compared++;
    if ({hready_out, hrdata} !== {1'b1, 32'h1234_5678}) begin
      mismatched++; $display("FAIL rd_complete: got ready=%b data=%h, expected 1 12345678", hready_out, hrdata);
    end
    next_cycle();
    rd_valid = 1'b0; rd_data = '0;
    @(negedge hclk);
    compared++;
    if ({hready_out, hrdata} !== {1'b1, 32'h1234_5678}) begin
      mismatched++; $display("FAIL rd_hold: got ready=%b data=%h, expected 1 12345678", hready_out, hrdata);
    end
    compared++;
    if (sbq.size() != 0) begin mismatched++; $display("FAIL rd_sb_empty: got %0d pending, expected 0", sbq.size()); end
    next_cycle();
    req_ready = 1'b0;
  endtask

  task automatic test_error();
    logic [31:0] addrs [2];
    addrs[0] = 32'h8C00_0000;
    addrs[1] = 32'h7FFF_FFFC;
    req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      addr_phase(2'b10, (k == 0), addrs[k]);
      @(negedge hclk);
      next_cycle();
      bus_idle();
      @(negedge hclk);
      compared++;
      if ({hresp, hready_out} !== 3'b010) begin
        mismatched++; $display("FAIL err1 %h: got resp=%b ready=%b, expected 01/0", addrs[k], hresp, hready_out);
      end
      next_cycle();
      @(negedge hclk);
      compared++;
      if ({hresp, hready_out} !== 3'b011) begin
        mismatched++; $display("FAIL err2 %h: got resp=%b ready=%b, expected 01/1", addrs[k], hresp, hready_out);
      end
      compared++;
      if (req_valid !== 1'b0) begin mismatched++; $display("FAIL err_no_push %h: got %b, expected 0", addrs[k], req_valid); end
      next_cycle();
      @(negedge hclk);
      compared++;
      if ({hresp, hready_out} !== 3'b001) begin
        mismatched++; $display("FAIL err_done %h: got resp=%b ready=%b, expected 00/1", addrs[k], hresp, hready_out);
      end
      next_cycle();
    end
  endtask

  task automatic test_ignored();
    logic [1:0]  tr [4];
    logic        sl [4];
    logic [31:0] ad [4];
    tr[0] = 2'b01; sl[0] = 1'b1; ad[0] = 32'h8C00_0000;
    tr[1] = 2'b00; sl[1] = 1'b1; ad[1] = 32'h8000_0000;
    tr[2] = 2'b10; sl[2] = 1'b0; ad[2] = 32'h8C00_0000;
    tr[3] = 2'b10; sl[3] = 1'b0; ad[3] = 32'h8000_0000;
    req_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      hsel_bridge = sl[p]; htrans = tr[p]; hwrite = 1'b1; haddr = ad[p];
      @(negedge hclk);
      next_cycle();
      bus_idle(); hwdata = 32'h5555_5555;
      @(negedge hclk);
      compared++;
      if ({hready_out, hresp} !== 3'b100) begin
        mismatched++; $display("FAIL ign_okay %0d: got ready=%b resp=%b, expected 1/00", p, hready_out, hresp);
      end
      next_cycle();
      @(negedge hclk);
      compared++;
      if (req_valid !== 1'b0) begin mismatched++; $display("FAIL ign_no_push %0d: got %b, expected 0", p, req_valid); end
      next_cycle();
    end
    hwdata = '0;
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b0;
    addr_phase(2'b10, 1'b1, 32'h8000_0100);
    expect_req(1'b1, 32'h8000_0100, 32'h0000_00B0, 3'b001);
    @(negedge hclk);
    next_cycle();
    hwdata = 32'h0000_00B0; addr_phase(2'b11, 1'b1, 32'h8000_0104);
    expect_req(1'b1, 32'h8000_0104, 32'h0000_00B1, 3'b001);
    @(negedge hclk);
    next_cycle();
    hwdata = 32'h0000_00B1; addr_phase(2'b10, 1'b0, 32'h8800_0000);
    @(negedge hclk);
    next_cycle();
    bus_idle(); hwdata = '0;
    @(negedge hclk);
    compared++;
    if ({hready_out, req_valid} !== 2'b01) begin
      mismatched++; $display("FAIL rm_pre: got ready=%b valid=%b, expected 0 1", hready_out, req_valid);
    end
    #2 hreset = 1'b1;
    #1;
    compared++;
    if ({req_valid, hready_out, hresp} !== 4'b0100) begin
      mismatched++;
      $display("FAIL rm_async: got valid=%b ready=%b resp=%b, expected 0 1 00", req_valid, hready_out, hresp);
    end
    sbq.delete();
    next_cycle();
    next_cycle();
    hreset = 1'b0;
    req_ready = 1'b1;
    addr_phase(2'b10, 1'b1, 32'h8400_0020);
    expect_req(1'b1, 32'h8400_0020, 32'hCAFE_F00D, 3'b010);
    @(negedge hclk);
    next_cycle();
    bus_idle(); hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    compared++;
    if (hready_out !== 1'b1) begin mismatched++; $display("FAIL rm_fresh_ready: got %b, expected 1", hready_out); end
    next_cycle();
    hwdata = '0;
    @(negedge hclk);
    compared++;
    if ({req_valid, req_addr} !== {1'b1, 32'h8400_0020}) begin
      mismatched++; $display("FAIL rm_fresh_head: got v=%b a=%h, expected 1 84000020", req_valid, req_addr);
    end
    next_cycle();
    compared++;
    if (sbq.size() != 0) begin mismatched++; $display("FAIL rm_sb_empty: got %0d pending, expected 0", sbq.size()); end
    req_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_error();
    test_ignored();
    test_reset_mid();
    repeat (2) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
